// File: rtl/i2c_config_sequencer.sv
// Register-init sequencer: walks a {reg_addr,value} table and writes each entry to the HDMI TX
// over an I2C controller handshake, with NACK retry/back-off. Optional HPD re-init: I2C_CFG_HPD_REINIT_EN.
module i2c_config_sequencer #(
    parameter int         TABLE_DEPTH    = 12,
    parameter int         IDX_W          = 6,
    parameter logic [7:0] SLAVE_ADDR     = 8'h72,
    parameter int         MAX_RETRY      = 3,
    parameter int         POWERUP_CYCLES = 10_000_000,
    parameter int         BACKOFF_CYCLES = 5000
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             interrupt,
    input  logic             start_cfg,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_data,
    output logic             txn_start,
    output logic [7:0]       txn_slave_addr,
    output logic [15:0]      txn_reg_data,
    input  logic             txn_busy,
    input  logic             txn_done,
    input  logic             txn_nack,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_error,
    output logic [IDX_W-1:0] fail_index
);

    localparam int CNT_MAX = (POWERUP_CYCLES > BACKOFF_CYCLES) ? POWERUP_CYCLES : BACKOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] BO_LAST  = CNT_W'((BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);

    localparam logic [2:0] S_PWRUP   = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_FAIL    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [15:0]      reg_data_q, reg_data_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic             hpd_fall;
    logic             rerun;

`ifdef I2C_CFG_HPD_REINIT_EN
    // interrupt idles high, so the synchroniser resets to 1 to avoid a false edge after reset
    logic int_meta_q, int_sync_q, int_prev_q;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            int_meta_q <= 1'b1;
            int_sync_q <= 1'b1;
            int_prev_q <= 1'b1;
        end else begin
            int_meta_q <= interrupt;
            int_sync_q <= int_meta_q;
            int_prev_q <= int_sync_q;
        end
    end

    assign hpd_fall = int_prev_q & ~int_sync_q;
`else
    logic unused_interrupt;
    assign unused_interrupt = interrupt;
    assign hpd_fall         = 1'b0;
`endif

    assign rerun = start_cfg | hpd_fall;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        reg_data_d = reg_data_q;
        start_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: begin
                reg_data_d = tbl_data;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (!txn_busy) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (txn_done) begin
                    if (!txn_nack) begin
                        state_d = S_NEXT;
                    end else if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        cnt_d   = '0;
                        state_d = S_BACKOFF;
                    end else begin
                        error_d    = 1'b1;
                        busy_d     = 1'b0;
                        fail_idx_d = idx_q;
                        state_d    = S_FAIL;
                    end
                end
            end
            S_BACKOFF: begin
                // retry re-uses the already captured reg_data, so go straight back to ISSUE
                if (cnt_q == BO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE, S_FAIL: begin
                if (rerun) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_PWRUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            reg_data_q <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            reg_data_q <= reg_data_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign tbl_index      = idx_q;
    assign txn_start      = start_q;
    assign txn_slave_addr = SLAVE_ADDR;
    assign txn_reg_data   = reg_data_q;
    assign cfg_busy       = busy_q;
    assign cfg_done       = done_q;
    assign cfg_error      = error_q;
    assign fail_index     = fail_idx_q;

    a_done_error_exclusive: assert property (@(posedge clock_50) disable iff (!reset)
        !(done_q && error_q));
    a_idle_only_terminal: assert property (@(posedge clock_50) disable iff (!reset)
        (!busy_q) == (state_q == S_DONE || state_q == S_FAIL));

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a small I2C controller responder model.
`timescale 1ns/1ps
module tb_i2c_config_sequencer;

    localparam int IDX_W    = 6;
    localparam int RESP_LAT = 3;

    logic             clock_50 = 1'b0;
    logic             reset;
    logic             interrupt;
    logic             start_cfg;
    logic [IDX_W-1:0] tbl_index;
    logic [15:0]      tbl_data;
    logic             txn_start;
    logic [7:0]       txn_slave_addr;
    logic [15:0]      txn_reg_data;
    logic             txn_busy;
    logic             txn_done;
    logic             txn_nack;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_error;
    logic [IDX_W-1:0] fail_index;

    logic [15:0] table_mem [12] = '{16'h4100, 16'h9803, 16'h9A70, 16'h9C30, 16'h9D61, 16'hA2A4,
                                    16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1602, 16'h1800};

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [15:0] wr_data[$];
    int          wr_idx[$];
    int          wr_cyc[$];
    int nack_idx    = -1;
    int nack_left   = 0;
    int nack_always = -1;
    int   r_idx;
    logic r_nack;
    logic r_abort;

    always #10 clock_50 = ~clock_50;

    assign tbl_data = (tbl_index < 12) ? table_mem[tbl_index] : 16'hDEAD;

    i2c_config_sequencer #(
        .TABLE_DEPTH(12), .IDX_W(IDX_W), .SLAVE_ADDR(8'h72), .MAX_RETRY(3),
        .POWERUP_CYCLES(20), .BACKOFF_CYCLES(8)
    ) dut (
        .clock_50(clock_50), .reset(reset), .interrupt(interrupt), .start_cfg(start_cfg),
        .tbl_index(tbl_index), .tbl_data(tbl_data), .txn_start(txn_start),
        .txn_slave_addr(txn_slave_addr), .txn_reg_data(txn_reg_data), .txn_busy(txn_busy),
        .txn_done(txn_done), .txn_nack(txn_nack), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .fail_index(fail_index)
    );

    always @(posedge clock_50) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // controller model: logs every request, answers RESP_LAT cycles later, aborts on reset
    initial begin
        txn_busy = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
        forever begin
            @(posedge clock_50); #1;
            if (reset && txn_start) begin
                r_idx = int'(tbl_index);
                wr_data.push_back(txn_reg_data); wr_idx.push_back(r_idx); wr_cyc.push_back(cyc);
                r_nack = 1'b0;
                if (r_idx == nack_always) r_nack = 1'b1;
                else if (r_idx == nack_idx && nack_left > 0) begin r_nack = 1'b1; nack_left--; end
                txn_busy = 1'b1;
                r_abort  = 1'b0;
                for (int k = 0; k < RESP_LAT; k++) begin
                    @(posedge clock_50); #1;
                    if (!reset) begin r_abort = 1'b1; break; end
                end
                if (!r_abort) begin
                    txn_done = 1'b1; txn_nack = r_nack;
                    @(posedge clock_50); #1;
                end
                txn_done = 1'b0; txn_nack = 1'b0; txn_busy = 1'b0;
            end
        end
    end

    task automatic clear_log();
        wr_data.delete(); wr_idx.delete(); wr_cyc.delete();
    endtask

    task automatic pulse_start();
        @(posedge clock_50); #2 start_cfg = 1'b1;
        @(posedge clock_50); #2 start_cfg = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !(cfg_done === 1'b1); i++) begin
            @(posedge clock_50); #2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; interrupt = 1'b1; start_cfg = 1'b0;
        repeat (3) @(posedge clock_50);
        #2;
        checks++; if (txn_start !== 1'b0) begin errors++; $display("FAIL reset_txn_start: got %0b exp 0", txn_start); end
        checks++; if (tbl_index !== '0) begin errors++; $display("FAIL reset_tbl_index: got %0d exp 0", tbl_index); end
        checks++; if (txn_reg_data !== 16'h0) begin errors++; $display("FAIL reset_reg_data: got %h exp 0000", txn_reg_data); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_cfg_busy: got %0b exp 1", cfg_busy); end
        checks++; if (cfg_done !== 1'b0 || cfg_error !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %0b%0b exp 00", cfg_done, cfg_error); end
        checks++; if (fail_index !== '0) begin errors++; $display("FAIL reset_fail_index: got %0d exp 0", fail_index); end
        checks++; if (txn_slave_addr !== 8'h72) begin errors++; $display("FAIL slave_addr: got %h exp 72", txn_slave_addr); end
    endtask

    task automatic test_all_ack();
        clear_log();
        @(posedge clock_50); #2 reset = 1'b1;
        repeat (10) @(posedge clock_50);
        #2;
        checks++; if (wr_data.size() != 0 || cfg_busy !== 1'b1) begin errors++; $display("FAIL pwrup_idle: got writes=%0d busy=%0b exp 0/1", wr_data.size(), cfg_busy); end
        wait_done(2000);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL ack_done: got %0b exp 1", cfg_done); end
        checks++; if (wr_data.size() != 12) begin errors++; $display("FAIL ack_count: got %0d exp 12", wr_data.size()); end
        if (wr_data.size() == 12) begin
            checks++; if (wr_data[0] !== 16'h4100) begin errors++; $display("FAIL ack_first: got %h exp 4100", wr_data[0]); end
            checks++; if (wr_data[11] !== 16'h1800) begin errors++; $display("FAIL ack_last: got %h exp 1800", wr_data[11]); end
            checks++; if (wr_cyc[0] < 20) begin errors++; $display("FAIL ack_pwrup: got cycle %0d exp >=20", wr_cyc[0]); end
            for (int i = 0; i < 12; i++) begin
                checks++; if (wr_data[i] !== table_mem[i]) begin errors++; $display("FAIL ack_entry%0d: got %h exp %h", i, wr_data[i], table_mem[i]); end
            end
        end
        checks++; if (cfg_busy !== 1'b0 || cfg_error !== 1'b0) begin errors++; $display("FAIL ack_status: got busy=%0b err=%0b exp 0/0", cfg_busy, cfg_error); end
        repeat (30) @(posedge clock_50);
        #2;
        checks++; if (wr_data.size() != 12) begin errors++; $display("FAIL ack_quiet: got %0d exp 12", wr_data.size()); end
    endtask

    task automatic test_start_latency();
        clear_log();
        @(posedge clock_50); #2 start_cfg = 1'b1;
        @(posedge clock_50); #2 start_cfg = 1'b0;
        checks++; if (cfg_done !== 1'b0 || cfg_busy !== 1'b1) begin errors++; $display("FAIL lat_clear: got done=%0b busy=%0b exp 0/1", cfg_done, cfg_busy); end
        checks++; if (txn_start !== 1'b0) begin errors++; $display("FAIL lat_c1: got %0b exp 0", txn_start); end
        @(posedge clock_50); #2;
        checks++; if (txn_start !== 1'b0) begin errors++; $display("FAIL lat_c2: got %0b exp 0", txn_start); end
        @(posedge clock_50); #2;
        checks++; if (txn_start !== 1'b1 || txn_reg_data !== 16'h4100) begin errors++; $display("FAIL lat_c3: got start=%0b data=%h exp 1/4100", txn_start, txn_reg_data); end
        wait_done(2000);
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL lat_run: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
    endtask

    task automatic test_nack_retry();
        int c5[$];
        clear_log();
        nack_idx = 5; nack_left = 2;
        pulse_start();
        wait_done(2000);
        nack_idx = -1;
        for (int i = 0; i < wr_idx.size(); i++) if (wr_idx[i] == 5) c5.push_back(wr_cyc[i]);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL retry_done: got %0b exp 1", cfg_done); end
        checks++; if (wr_data.size() != 14) begin errors++; $display("FAIL retry_total: got %0d exp 14", wr_data.size()); end
        checks++; if (c5.size() != 3) begin errors++; $display("FAIL retry_e5_count: got %0d exp 3", c5.size()); end
        if (c5.size() == 3) begin
            checks++; if (c5[1] - c5[0] < 8 || c5[2] - c5[1] < 8) begin errors++; $display("FAIL retry_gap: got %0d,%0d exp >=8", c5[1] - c5[0], c5[2] - c5[1]); end
        end
    endtask

    task automatic test_nack_fail();
        int n7, n8;
        clear_log();
        nack_always = 7;
        pulse_start();
        for (int i = 0; i < 2000 && !(cfg_error === 1'b1); i++) begin @(posedge clock_50); #2; end
        nack_always = -1;
        n7 = 0; n8 = 0;
        foreach (wr_idx[i]) begin if (wr_idx[i] == 7) n7++; if (wr_idx[i] == 8) n8++; end
        checks++; if (cfg_error !== 1'b1 || cfg_done !== 1'b0) begin errors++; $display("FAIL fail_flags: got err=%0b done=%0b exp 1/0", cfg_error, cfg_done); end
        checks++; if (fail_index !== 6'd7) begin errors++; $display("FAIL fail_index: got %0d exp 7", fail_index); end
        checks++; if (n7 != 4 || n8 != 0) begin errors++; $display("FAIL fail_writes: got e7=%0d e8=%0d exp 4/0", n7, n8); end
        checks++; if (cfg_busy !== 1'b0 || wr_data.size() != 11) begin errors++; $display("FAIL fail_busy: got busy=%0b writes=%0d exp 0/11", cfg_busy, wr_data.size()); end
    endtask

    task automatic test_fail_restart();
        clear_log();
        @(posedge clock_50); #2 start_cfg = 1'b1;
        @(posedge clock_50); #2 start_cfg = 1'b0;
        checks++; if (cfg_error !== 1'b0 || cfg_busy !== 1'b1) begin errors++; $display("FAIL rst_err_clear: got err=%0b busy=%0b exp 0/1", cfg_error, cfg_busy); end
        @(posedge clock_50); #2;
        @(posedge clock_50); #2;
        checks++; if (txn_start !== 1'b1 || tbl_index !== '0) begin errors++; $display("FAIL rst_restart: got start=%0b idx=%0d exp 1/0", txn_start, tbl_index); end
        wait_done(2000);
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL rst_run: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
    endtask

    task automatic test_busy_start();
        clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && wr_data.size() < 5; i++) begin @(posedge clock_50); #2; end
        pulse_start();
        wait_done(2000);
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL busy_ignore: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
        for (int i = 0; i < wr_idx.size(); i++) begin
            checks++; if (wr_idx[i] != i) begin errors++; $display("FAIL busy_order%0d: got idx %0d exp %0d", i, wr_idx[i], i); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && wr_data.size() < 5; i++) begin @(posedge clock_50); #2; end
        @(posedge clock_50); #2;
        checks++; if (txn_busy !== 1'b1 || wr_idx.size() != 5) begin errors++; $display("FAIL mid_setup: got busy=%0b writes=%0d exp 1/5", txn_busy, wr_idx.size()); end
        reset = 1'b0;
        #1;
        checks++; if (tbl_index !== '0 || txn_reg_data !== 16'h0 || txn_start !== 1'b0) begin errors++; $display("FAIL mid_async: got idx=%0d data=%h start=%0b exp 0/0000/0", tbl_index, txn_reg_data, txn_start); end
        checks++; if (cfg_busy !== 1'b1 || cfg_done !== 1'b0 || cfg_error !== 1'b0) begin errors++; $display("FAIL mid_status: got %0b%0b%0b exp 100", cfg_busy, cfg_done, cfg_error); end
        repeat (3) @(posedge clock_50);
        #2 clear_log();
        @(posedge clock_50); #2 reset = 1'b1;
        wait_done(2000);
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL mid_rerun: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
        if (wr_data.size() > 0) begin
            checks++; if (wr_cyc[0] < 20 || wr_data[0] !== 16'h4100) begin errors++; $display("FAIL mid_pwrup: got cycle %0d data %h exp >=20/4100", wr_cyc[0], wr_data[0]); end
        end
    endtask

    task automatic test_hpd();
        clear_log();
        @(posedge clock_50); #2 interrupt = 1'b0;
`ifdef I2C_CFG_HPD_REINIT_EN
        for (int i = 0; i < 2000 && !(wr_data.size() == 12 && cfg_done === 1'b1); i++) begin @(posedge clock_50); #2; end
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL hpd_rerun: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
        interrupt = 1'b1;
        repeat (4) @(posedge clock_50);
        #2 clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && wr_data.size() < 3; i++) begin @(posedge clock_50); #2; end
        interrupt = 1'b0;
        wait_done(2000);
        repeat (30) @(posedge clock_50);
        #2;
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 12) begin errors++; $display("FAIL hpd_busy_drop: got done=%0b writes=%0d exp 1/12", cfg_done, wr_data.size()); end
`else
        repeat (100) @(posedge clock_50);
        #2;
        checks++; if (cfg_done !== 1'b1 || wr_data.size() != 0) begin errors++; $display("FAIL hpd_unused: got done=%0b writes=%0d exp 1/0", cfg_done, wr_data.size()); end
`endif
        interrupt = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_ack();
        test_start_latency();
        test_nack_retry();
        test_nack_fail();
        test_fail_restart();
        test_busy_start();
        test_reset_mid();
        test_hpd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
